multicycle_control_unit: RTL and testbench

Multi-cycle sequencer for the RISC-V core. It steps the shared datapath (ALU, register file, immediate generator, unified instruction/data memory) through fetch, decode, execute, memory and writeback for R-type, ld, sd and beq. Memory accesses use a req/ack handshake. The block also counts retired instructions and flags illegal opcodes.

---
 rtl/riscv_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_control_unit_mem_wait_timer.sv | 37 +++
 rtl/multicycle_control_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: state encoding,
// supported opcodes, ALU control codes and the bundle of datapath controls.
package riscv_ctrl_pkg;

  // Sequencer states; the encoding is visible on the debug State port.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_ALU_WB   = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_HALT     = 4'd15
  } state_e;

  // Supported major opcodes (Instruction[6:0]).
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  // ALU operation select.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  // ALU second operand select.
  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_FOUR = 2'b01,
    SRC_B_IMM  = 2'b10
  } alu_src_b_e;

  // Width of the memory wait counter; covers MEM_TIMEOUT up to 255.
  localparam int unsigned TIMER_W = 8;

  // All datapath controls driven by the sequencer.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // States that hold a memory request open until Mem_Ack.
  function automatic logic is_req_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Wait-cycle counter for memory requests: counts consecutive cycles of an open
// request without Mem_Ack and flags the last allowed wait cycle going unanswered.
module mem_wait_timer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic expired
);

  // Counter value seen during the TIMEOUT-th wait cycle of a request.
  localparam logic [TIMER_W-1:0] LAST_WAIT = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q;

  // Count wait cycles; an ack or any non-request state rearms the counter,
  // so every request state is entered with a cleared count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      count_q <= '0;
    end else if (!active || ack) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

  // An ack on the final wait cycle wins over the timeout.
  assign expired = active && !ack && (count_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the RISC-V core: steps the shared datapath through
// fetch/decode/execute/memory/writeback for R-type, ld, sd and beq, handles the
// memory req/ack handshake with a timeout, counts retired instructions and
// flags illegal opcodes.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int OPC_W       = 7,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Zero,
  input  logic             Mem_Ack,
  output logic             Mem_Req,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             I_or_D,
  output logic             IR_Write,
  output logic             PC_Write,
  output logic             PC_Write_Cond,
  output logic             PC_Src,
  output logic             ALU_Src_A,
  output logic [1:0]       ALU_Src_B,
  output logic [1:0]       ALU_Op,
  output logic             Reg_Write,
  output logic             Mem_to_Reg,
  output logic             Illegal_Instr,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Instr_Count,
  output logic [3:0]       State
);

  state_e           state_q;
  state_e           next_state;
  ctrl_t            ctrl;
  logic             in_req;
  logic             wait_expired;
  logic             retire;
  logic             set_illegal;
  logic             set_timeout;
  logic             illegal_q;
  logic             timeout_q;
  logic [CNT_W-1:0] count_q;

  // The branch condition is resolved in the datapath (PC_Write_Cond & Zero);
  // the sequencer itself never looks at Zero.
  logic unused_zero;
  assign unused_zero = Zero;

  assign in_req = is_req_state(state_q);

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (in_req),
    .ack     (Mem_Ack),
    .expired (wait_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state decode, plus the retire and sticky-flag set strobes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    next_state  = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (Mem_Ack) begin
          next_state = ST_DECODE;
        end else if (wait_expired) begin
          next_state  = ST_HALT;
          set_timeout = 1'b1;
        end
      end
      ST_DECODE: begin
        case (Opcode)
          OPC_LD, OPC_SD: next_state = ST_MEM_ADDR;
          OPC_R:          next_state = ST_EXEC_R;
          OPC_BEQ:        next_state = ST_BRANCH;
          default: begin
            next_state  = ST_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        next_state = (Opcode == OPC_LD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        if (Mem_Ack) begin
          next_state = ST_MEM_WB;
        end else if (wait_expired) begin
          next_state  = ST_HALT;
          set_timeout = 1'b1;
        end
      end
      ST_MEM_WB: begin
        next_state = ST_FETCH;
        retire     = 1'b1;
      end
      ST_MEM_WR: begin
        if (Mem_Ack) begin
          next_state = ST_FETCH;
          retire     = 1'b1;
        end else if (wait_expired) begin
          next_state  = ST_HALT;
          set_timeout = 1'b1;
        end
      end
      ST_EXEC_R: begin
        next_state = ST_ALU_WB;
      end
      ST_ALU_WB, ST_BRANCH: begin
        next_state = ST_FETCH;
        retire     = 1'b1;
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        // Unused encodings park the sequencer until reset.
        next_state = ST_HALT;
      end
    endcase
  end

  // Moore control decode; only the FETCH-cycle IR/PC loads follow Mem_Ack.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = Mem_Ack;
        ctrl.pc_write  = Mem_Ack;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_ALU_WB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_RS2;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
    // The reset state is FETCH, which would otherwise raise a memory request;
    // holding rst_n low forces every control quiet immediately.
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  // Sticky error flags; they clear only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign Mem_Req       = ctrl.mem_req;
  assign Mem_Read      = ctrl.mem_read;
  assign Mem_Write     = ctrl.mem_write;
  assign I_or_D        = ctrl.i_or_d;
  assign IR_Write      = ctrl.ir_write;
  assign PC_Write      = ctrl.pc_write;
  assign PC_Write_Cond = ctrl.pc_write_cond;
  assign PC_Src        = ctrl.pc_src;
  assign ALU_Src_A     = ctrl.alu_src_a;
  assign ALU_Src_B     = ctrl.alu_src_b;
  assign ALU_Op        = ctrl.alu_op;
  assign Reg_Write     = ctrl.reg_write;
  assign Mem_to_Reg    = ctrl.mem_to_reg;
  assign Illegal_Instr = illegal_q;
  assign Mem_Timeout   = timeout_q;
  assign Instr_Count   = count_q;
  assign State         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: a per-instruction plan of
// expected phases drives Mem_Ack and is compared cycle by cycle, a vector table
// pins latencies, random instruction streams exercise wait states, and
// hand-written sequences cover timeout, illegal opcode and mid-access reset.
module tb_multicycle_control_unit;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  // Phase numbers as they appear on the debug State port.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_RD = 3,
                 P_MEM_WB = 4, P_MEM_WR = 5, P_EXEC_R = 6, P_ALU_WB = 7,
                 P_BRANCH = 8, P_HALT = 15;

  logic        clk;
  logic        rst_n;
  logic [6:0]  Opcode;
  logic        Zero;
  logic        Mem_Ack;
  logic        Mem_Req, Mem_Read, Mem_Write, I_or_D, IR_Write, PC_Write;
  logic        PC_Write_Cond, PC_Src, ALU_Src_A, Reg_Write, Mem_to_Reg;
  logic [1:0]  ALU_Src_B, ALU_Op;
  logic        Illegal_Instr, Mem_Timeout;
  logic [31:0] Instr_Count;
  logic [3:0]  State;

  logic [14:0] ctrl_vec;
  assign ctrl_vec = {Mem_Req, Mem_Read, Mem_Write, I_or_D, IR_Write, PC_Write,
                     PC_Write_Cond, PC_Src, ALU_Src_A, ALU_Src_B, ALU_Op,
                     Reg_Write, Mem_to_Reg};

  multicycle_control_unit #(
    .OPC_W       (7),
    .CNT_W       (32),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Opcode        (Opcode),
    .Zero          (Zero),
    .Mem_Ack       (Mem_Ack),
    .Mem_Req       (Mem_Req),
    .Mem_Read      (Mem_Read),
    .Mem_Write     (Mem_Write),
    .I_or_D        (I_or_D),
    .IR_Write      (IR_Write),
    .PC_Write      (PC_Write),
    .PC_Write_Cond (PC_Write_Cond),
    .PC_Src        (PC_Src),
    .ALU_Src_A     (ALU_Src_A),
    .ALU_Src_B     (ALU_Src_B),
    .ALU_Op        (ALU_Op),
    .Reg_Write     (Reg_Write),
    .Mem_to_Reg    (Mem_to_Reg),
    .Illegal_Instr (Illegal_Instr),
    .Mem_Timeout   (Mem_Timeout),
    .Instr_Count   (Instr_Count),
    .State         (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model_count;

  typedef struct {
    int st;
    bit ack;
  } step_t;

  typedef struct {
    string      name;
    logic [6:0] opc;
    bit         z;
    int         fw;
    int         dw;
    int         exp_lat;
    int         exp_inc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input int st, input bit ack);
    step_t s;
    s.st  = st;
    s.ack = ack;
    return s;
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  // Control word each phase must present, written from the phase descriptions.
  function automatic logic [14:0] exp_ctrl(input int st, input bit ack);
    logic req, rd, wr, iod, irw, pcw, pcwc, pcs, sa, rw, m2r;
    logic [1:0] sb, op;
    {req, rd, wr, iod, irw, pcw, pcwc, pcs, sa, rw, m2r} = '0;
    sb = 2'b00;
    op = 2'b00;
    case (st)
      P_FETCH:    begin req = 1; rd = 1; sb = 2'b01; irw = ack; pcw = ack; end
      P_DECODE:   begin sb = 2'b10; end
      P_MEM_ADDR: begin sa = 1; sb = 2'b10; end
      P_MEM_RD:   begin req = 1; rd = 1; iod = 1; end
      P_MEM_WB:   begin rw = 1; m2r = 1; end
      P_MEM_WR:   begin req = 1; wr = 1; iod = 1; end
      P_EXEC_R:   begin sa = 1; op = 2'b10; end
      P_ALU_WB:   begin rw = 1; end
      P_BRANCH:   begin sa = 1; op = 2'b01; pcwc = 1; pcs = 1; end
      default:    ;
    endcase
    return {req, rd, wr, iod, irw, pcw, pcwc, pcs, sa, sb, op, rw, m2r};
  endfunction

  // Run one instruction: fw/dw are the unanswered wait cycles before the fetch
  // and data acks. lat returns the cycle count until the DUT is back in FETCH.
  task automatic run_instr(input logic [6:0] opc, input bit z, input int fw,
                           input int dw, output int lat);
    step_t plan[$];
    bit    seen;
    plan = {};
    for (int k = 0; k < fw; k++) plan.push_back(mk(P_FETCH, 1'b0));
    plan.push_back(mk(P_FETCH, 1'b1));
    plan.push_back(mk(P_DECODE, rnd_bit()));
    case (opc)
      OPC_LD: begin
        plan.push_back(mk(P_MEM_ADDR, rnd_bit()));
        for (int k = 0; k < dw; k++) plan.push_back(mk(P_MEM_RD, 1'b0));
        plan.push_back(mk(P_MEM_RD, 1'b1));
        plan.push_back(mk(P_MEM_WB, rnd_bit()));
      end
      OPC_SD: begin
        plan.push_back(mk(P_MEM_ADDR, rnd_bit()));
        for (int k = 0; k < dw; k++) plan.push_back(mk(P_MEM_WR, 1'b0));
        plan.push_back(mk(P_MEM_WR, 1'b1));
      end
      OPC_R: begin
        plan.push_back(mk(P_EXEC_R, rnd_bit()));
        plan.push_back(mk(P_ALU_WB, rnd_bit()));
      end
      OPC_BEQ: plan.push_back(mk(P_BRANCH, rnd_bit()));
      default: plan.push_back(mk(P_HALT, rnd_bit()));
    endcase
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < plan.size(); i++) begin
      @(negedge clk);
      Opcode  = opc;
      Zero    = z;
      Mem_Ack = plan[i].ack;
      #1;
      check("state", 64'(State), 64'(plan[i].st));
      check("ctrl", 64'(ctrl_vec), 64'(exp_ctrl(plan[i].st, plan[i].ack)));
      check("instr_count", 64'(Instr_Count), 64'(model_count));
      @(posedge clk);
      #1;
      if (State != 4'd0) seen = 1'b1;
      else if (seen && lat == 0) lat = i + 1;
    end
    if (opc == OPC_LD || opc == OPC_SD || opc == OPC_R || opc == OPC_BEQ)
      model_count = model_count + 32'd1;
  endtask

  // One raw clock cycle with the given inputs.
  task automatic cycle(input logic [6:0] opc, input bit ack);
    @(negedge clk);
    Opcode  = opc;
    Mem_Ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    Mem_Ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_count = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    logic [31:0] start;

    vecs[0] = '{"r_type",        OPC_R,   1'b0, 0, 0,  4,  1};
    vecs[1] = '{"ld",            OPC_LD,  1'b0, 0, 0,  5,  1};
    vecs[2] = '{"sd",            OPC_SD,  1'b0, 0, 0,  4,  1};
    vecs[3] = '{"beq_zero1",     OPC_BEQ, 1'b1, 0, 0,  3,  1};
    vecs[4] = '{"beq_zero0",     OPC_BEQ, 1'b0, 0, 0,  3,  1};
    vecs[5] = '{"ld_wait3",      OPC_LD,  1'b0, 0, 3,  8,  1};
    vecs[6] = '{"sd_ack_at_15",  OPC_SD,  1'b0, 2, 14, 20, 1};
    vecs[7] = '{"r_fetch_wait4", OPC_R,   1'b1, 4, 0,  8,  1};

    rst_n       = 1'b0;
    Opcode      = OPC_R;
    Zero        = 1'b0;
    Mem_Ack     = 1'b0;
    model_count = '0;

    // Reset values while rst_n is held low.
    #1;
    check("reset_state", 64'(State), 64'd0);
    check("reset_ctrl", 64'(ctrl_vec), 64'd0);
    check("reset_count", 64'(Instr_Count), 64'd0);
    check("reset_flags", 64'({Illegal_Instr, Mem_Timeout}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table: latency and retire count per instruction shape.
    for (int v = 0; v < 8; v++) begin
      start = model_count;
      run_instr(vecs[v].opc, vecs[v].z, vecs[v].fw, vecs[v].dw, lat);
      check({vecs[v].name, "_latency"}, 64'(lat), 64'(vecs[v].exp_lat));
      check({vecs[v].name, "_count"}, 64'(Instr_Count), 64'(start + 32'(vecs[v].exp_inc)));
    end

    // Random legal instruction stream with random wait states.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] opc;
      case ($urandom_range(0, 3))
        0:       opc = OPC_LD;
        1:       opc = OPC_SD;
        2:       opc = OPC_R;
        default: opc = OPC_BEQ;
      endcase
      run_instr(opc, rnd_bit(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), lat);
    end
    check("random_final_count", 64'(Instr_Count), 64'(model_count));
    check("no_flags_after_random", 64'({Illegal_Instr, Mem_Timeout}), 64'd0);

    // Reset asserted mid-way through a load's data access.
    cycle(OPC_LD, 1'b1);
    cycle(OPC_LD, 1'b0);
    cycle(OPC_LD, 1'b0);
    check("mid_reset_in_mem_rd", 64'(State), 64'(P_MEM_RD));
    @(negedge clk);
    Mem_Ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_ctrl", 64'(ctrl_vec), 64'd0);
    check("mid_reset_state", 64'(State), 64'd0);
    check("mid_reset_count", 64'(Instr_Count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_count = '0;
    #1;
    check("post_reset_fetch_req", 64'(ctrl_vec), 64'(exp_ctrl(P_FETCH, 1'b0)));
    run_instr(OPC_R, 1'b0, 0, 0, lat);
    check("post_reset_r_latency", 64'(lat), 64'd4);
    check("post_reset_r_count", 64'(Instr_Count), 64'd1);

    // Store whose ack never arrives: timeout after MEM_TIMEOUT wait cycles.
    do_reset();
    cycle(OPC_SD, 1'b1);
    cycle(OPC_SD, 1'b0);
    cycle(OPC_SD, 1'b0);
    for (int k = 0; k < MEM_TIMEOUT - 1; k++) begin
      cycle(OPC_SD, 1'b0);
      check("wr_req_held", 64'({State, Mem_Req, Mem_Write}), 64'({4'(P_MEM_WR), 2'b11}));
    end
    check("no_early_timeout", 64'(Mem_Timeout), 64'd0);
    cycle(OPC_SD, 1'b0);
    check("timeout_state", 64'(State), 64'(P_HALT));
    check("timeout_flag", 64'(Mem_Timeout), 64'd1);
    check("timeout_ctrl", 64'(ctrl_vec), 64'd0);
    check("timeout_count", 64'(Instr_Count), 64'd0);
    check("timeout_not_illegal", 64'(Illegal_Instr), 64'd0);

    // Unsupported opcode: HALT with a sticky flag, acks ignored.
    do_reset();
    cycle(OPC_BAD, 1'b1);
    cycle(OPC_BAD, 1'b0);
    check("illegal_state", 64'(State), 64'(P_HALT));
    for (int k = 0; k < 20; k++) begin
      cycle(OPC_BAD, rnd_bit());
      check("illegal_sticky", 64'({State, Illegal_Instr}), 64'({4'(P_HALT), 1'b1}));
    end
    check("illegal_ctrl", 64'(ctrl_vec), 64'd0);
    check("illegal_count", 64'(Instr_Count), 64'd0);
    check("illegal_no_timeout", 64'(Mem_Timeout), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
